// File: rtl/butterfly_engine.sv
// In-place sum/difference butterfly engine sweeping word pairs held in two
// external dual-port RAMs, with a start/busy/done handshake and sticky overflow.
module butterfly_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 9
) (
  input  logic              CLOCK_50_I,
  input  logic              resetn,
  input  logic              start,
  input  logic              sat_en,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] pair_count,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic              ram_wren,
  output logic [DATA_W-1:0] ram0_wdata_a,
  output logic [DATA_W-1:0] ram0_wdata_b,
  output logic [DATA_W-1:0] ram1_wdata_a,
  output logic [DATA_W-1:0] ram1_wdata_b,
  input  logic [DATA_W-1:0] ram0_q_a,
  input  logic [DATA_W-1:0] ram0_q_b,
  input  logic [DATA_W-1:0] ram1_q_a,
  input  logic [DATA_W-1:0] ram1_q_b
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] HALF_PAIRS = {1'b1, {(ADDR_W-1){1'b0}}};
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO  = ADDR_W'(0);
  localparam logic [DATA_W-1:0] SAT_MAX    = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_MIN    = {1'b1, {(DATA_W-1){1'b0}}};

  state_t              state_r;
  logic [ADDR_W-1:0]   remaining_r;
  logic                sat_r;

  logic [DATA_W:0]     d0a_s, s1a_s, d0b_s, s1b_s;
  logic                any_ovf_s;
  logic [ADDR_W-1:0]   clamped_s;

  function automatic logic [DATA_W:0] sext(input logic [DATA_W-1:0] v);
    return {v[DATA_W-1], v};
  endfunction

  // A DATA_W+1 result is out of range when its two top bits disagree.
  function automatic logic out_of_range(input logic [DATA_W:0] r);
    return r[DATA_W] ^ r[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] fit(input logic [DATA_W:0] r, input logic sat);
    logic [DATA_W-1:0] res;
    if (sat && out_of_range(r)) begin
      res = r[DATA_W] ? SAT_MIN : SAT_MAX;
    end else begin
      res = r[DATA_W-1:0];
    end
    return res;
  endfunction

  // Butterfly arithmetic on the operands returned by the RAMs.
  always_comb begin
    d0a_s     = sext(ram0_q_b) - sext(ram1_q_a);
    s1a_s     = sext(ram0_q_a) + sext(ram1_q_b);
    d0b_s     = sext(ram0_q_a) - sext(ram1_q_b);
    s1b_s     = sext(ram0_q_b) + sext(ram1_q_a);
    any_ovf_s = out_of_range(d0a_s) | out_of_range(s1a_s) |
                out_of_range(d0b_s) | out_of_range(s1b_s);
    if (pair_count > HALF_PAIRS) begin
      clamped_s = HALF_PAIRS;
    end else begin
      clamped_s = pair_count;
    end
  end

  assign ram0_wdata_a = fit(d0a_s, sat_r);
  assign ram1_wdata_a = fit(s1a_s, sat_r);
  assign ram0_wdata_b = fit(d0b_s, sat_r);
  assign ram1_wdata_b = fit(s1b_s, sat_r);

  // Sweep sequencer; all handshake and RAM control outputs are registered here.
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state_r     <= S_IDLE;
      remaining_r <= ADDR_ZERO;
      sat_r       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      ovf         <= 1'b0;
      ram_wren    <= 1'b0;
      ram_addr_a  <= ADDR_ZERO;
      ram_addr_b  <= ADDR_ONE;
    end else begin
      case (state_r)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sat_r       <= sat_en;
            ovf         <= 1'b0;
            ram_addr_a  <= {start_addr[ADDR_W-1:1], 1'b0};
            ram_addr_b  <= {start_addr[ADDR_W-1:1], 1'b1};
            remaining_r <= clamped_s;
            if (clamped_s == ADDR_ZERO) begin
              done    <= 1'b1;
              state_r <= S_DONE;
            end else begin
              busy    <= 1'b1;
              state_r <= S_READ;
            end
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_READ: begin
          ram_wren <= 1'b1;
          state_r  <= S_WRITE;
        end
        S_WRITE: begin
          ram_wren    <= 1'b0;
          ovf         <= ovf | any_ovf_s;
          ram_addr_a  <= ram_addr_a + ADDR_STEP;
          ram_addr_b  <= ram_addr_b + ADDR_STEP;
          remaining_r <= remaining_r - ADDR_ONE;
          if (remaining_r == ADDR_ONE) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= S_DONE;
          end else begin
            state_r <= S_READ;
          end
        end
        S_DONE: begin
          done    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          busy     <= 1'b0;
          done     <= 1'b0;
          ram_wren <= 1'b0;
          state_r  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/butterfly_engine.md
# butterfly_engine

Parametrised in-place sum/difference butterfly engine that sweeps a programmable range of word pairs held in two external dual-port RAMs (RAM0, RAM1). Per pair it reads four operands and writes four results back to the same addresses. Data width, address depth and wrap/saturate arithmetic are selectable, and a start/busy/done handshake lets a top-level FSM or switch-driven controller launch sweeps and detect their completion.

## Interface
- DATA_W, 8: word width of both RAMs and all arithmetic.
- ADDR_W, 9: RAM address width; depth = 2^ADDR_W, pairs per full sweep = 2^(ADDR_W-1).
- CLOCK_50_I  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  launch request, sampled only in S_IDLE.
- sat_en  in  1  0 = modulo wrap, 1 = signed saturation; latched at start.
- start_addr  in  ADDR_W  first pair base address; LSB ignored (forced even).
- pair_count  in  ADDR_W  number of pairs; values above 2^(ADDR_W-1) are clamped to 2^(ADDR_W-1).
- busy  out  1  high in S_READ/S_WRITE.
- done  out  1  one-cycle pulse at the end of a sweep.
- ovf  out  1  sticky; set if any result overflowed in the current sweep; cleared at start.
- ram_addr_a  out  ADDR_W  port-A address, shared by RAM0/RAM1 (even word k).
- ram_addr_b  out  ADDR_W  port-B address, shared (k+1).
- ram_wren  out  1  write enable for all four ports.
- ram0_wdata_a, ram0_wdata_b, ram1_wdata_a, ram1_wdata_b  out  DATA_W each  write data.
- ram0_q_a, ram0_q_b, ram1_q_a, ram1_q_b  in  DATA_W each  read data, valid 1 cycle after address.

## Operation
- Operands per pair k: A0=RAM0[k], B0=RAM0[k+1], A1=RAM1[k], B1=RAM1[k+1].
- Results: RAM0[k]=B0-A1; RAM1[k]=A0+B1; RAM0[k+1]=A0-B1; RAM1[k+1]=B0+A1.
- Write data is combinational from q_* and the latched sat_en; it is meaningful only while ram_wren=1.
- Arithmetic: operands are signed two's complement and are computed at DATA_W+1 bits. Wrap mode keeps the low DATA_W bits. Saturate mode clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- ovf is set on any write cycle where the DATA_W+1 result falls outside the signed range, in either mode.
- States:
  - S_IDLE: on start, latch sat_en, load ram_addr_a=start_addr&~1, ram_addr_b=that+1, remaining=clamped pair_count, and clear ovf. If remaining=0, go to S_DONE; otherwise go to S_READ.
  - S_READ: addresses stable; set ram_wren=1; go to S_WRITE.
  - S_WRITE: q valid and results written at the closing edge; clear ram_wren; advance both addresses by 2 (modulo 2^ADDR_W); decrement remaining; go to S_DONE if remaining was 1, else S_READ.
  - S_DONE: done=1 for one cycle; go to S_IDLE.
- start is ignored outside S_IDLE. A start held high in S_IDLE after done launches a new sweep.
- Address wrap: a sweep crossing the top of memory continues at pair 0/1.
- Reset mid-sweep forces S_IDLE immediately, with ram_wren=0. The pair in flight is not written; earlier pairs keep their results.

## Timing
- Reset values: busy=0, done=0, ovf=0, ram_wren=0, ram_addr_a=0, ram_addr_b=1, state=S_IDLE.
- Start sampled at edge E0. For N≥1 pairs, pair i is written at edge E(2i+2). done is high during the cycle after E(2N), and busy falls at the same edge.
- For N=0, done is high during the cycle after E0, and ram_wren is never asserted.
- Throughput: 2 cycles per pair. A full sweep at default parameters takes 512 cycles from start to done.
- ram_wren, addresses, busy, done and ovf are all registered outputs.

## Test plan
- Basic pair: RAM0[0..1]={10,50}, RAM1[0..1]={20,5}, start_addr=0, pair_count=1, wrap mode. Required: RAM0={30,5}, RAM1={15,70}, done after E2, ovf=0.
- Overflow: A0=100, B1=100, wrap mode. Required: RAM1[k]=0xC8, ovf=1. Same data with sat_en=1: required RAM1[k]=127, ovf=1; A0=-100, B1=100 gives RAM0[k+1]=-128.
- Full sweep: random RAM contents, start_addr=0, pair_count=256. Required: all 512 words match the golden model, done after E512, last addresses 510/511.
- Wrap and clamp: start_addr=511 (forced to 510), pair_count=2. Required: pairs 510/511 then 0/1 processed, no other words touched. pair_count=300: required 256 pairs processed.
- Zero count and ignored start: pair_count=0 gives done after E0 with no writes. start pulsed while busy is ignored, and the sweep count is unchanged.
- Reset mid-sweep: resetn low in S_READ of pair 3. Required: ram_wren=0 immediately, pairs 0–2 updated, pairs 3+ unchanged, all outputs at reset values.
